// File: rtl/ball_engine_pkg.sv
// Shared pong constants, coordinate types and FSM encoding for the ball engine
// and the graphics offset stage.
package ball_engine_pkg;

    localparam int unsigned POS_BITS = 10;

    // Field coordinates, and the one-bit-wider form used for every add/subtract.
    typedef logic [POS_BITS-1:0] pos_t;
    typedef logic [POS_BITS:0]   ext_t;

    localparam ext_t FIELD_W = ext_t'(620);
    localparam ext_t FIELD_H = ext_t'(360);
    localparam ext_t BALL_R  = ext_t'(8);
    localparam ext_t BAR1_X  = ext_t'(20);
    localparam ext_t BAR2_X  = ext_t'(600);
    localparam ext_t BAR_HW  = ext_t'(5);
    localparam ext_t BAR_HH  = ext_t'(30);
    localparam ext_t SPEED_X = ext_t'(2);
    localparam ext_t SPEED_Y = ext_t'(1);

    // Serve position.
    localparam pos_t CENTRE_X = pos_t'(FIELD_W >> 1);
    localparam pos_t CENTRE_Y = pos_t'(FIELD_H >> 1);

    localparam int unsigned SERVE_TICKS = 60;
    localparam int unsigned CNT_BITS    = $clog2(SERVE_TICKS);
    typedef logic [CNT_BITS-1:0] cnt_t;
    localparam cnt_t SERVE_LAST = cnt_t'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {
        StServe = 2'd0,
        StMove  = 2'd1,
        StGoal  = 2'd2
    } state_e;

    // |a-b| by compare-then-subtract so the difference never wraps.
    function automatic ext_t abs_diff(input ext_t a, input ext_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Game-side signals of the ball engine: step enable, serve control, paddle
// positions in; ball position and score pulses out.
interface ball_engine_if;
    import ball_engine_pkg::*;

    logic tick;
    logic serve_en;
    pos_t bar_1_y;
    pos_t bar_2_y;
    pos_t x_ball;
    pos_t y_ball;
    logic point1;
    logic point2;

    modport master (
        output tick, serve_en, bar_1_y, bar_2_y,
        input  x_ball, y_ball, point1, point2
    );

    modport slave (
        input  tick, serve_en, bar_1_y, bar_2_y,
        output x_ball, y_ball, point1, point2
    );

endinterface

// File: rtl/ball_engine_bounce_axis.sv
// One-dimensional position/direction register: steps on demand and clamps
// against [Min, Max], reversing direction at either limit.
module ball_engine_bounce_axis import ball_engine_pkg::*; #(
    parameter ext_t Min     = ext_t'(0),
    parameter ext_t Max     = ext_t'(1),
    parameter ext_t Step    = ext_t'(1),
    parameter pos_t Init    = pos_t'(0),
    parameter logic InitDir = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic step_i,
    input  logic load_i,
    output pos_t pos_o
);

    pos_t pos_q, pos_d;
    logic dir_q, dir_d;
    ext_t np;

    // Next position: step in the current direction, clamp and reflect at a limit.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        np    = dir_q ? ({1'b0, pos_q} + Step) : ({1'b0, pos_q} - Step);
        if (load_i) begin
            // Re-centre keeps the direction of travel.
            pos_d = Init;
        end else if (step_i) begin
            if (np >= Max) begin
                pos_d = pos_t'(Max);
                dir_d = 1'b0;
            end else if (np <= Min) begin
                pos_d = pos_t'(Min);
                dir_d = 1'b1;
            end else begin
                pos_d = pos_t'(np);
            end
        end
    end

    // Axis state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pos_q <= Init;
            dir_q <= InitDir;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/ball_engine.sv
// Pong ball physics: serve delay, wall and paddle bounces, goal detection and
// one-cycle score pulses. Advances only on the game-step tick.
module ball_engine (
    input  logic          mclk,
    input  logic          reset,
    ball_engine_if.slave  bus_io
);
    import ball_engine_pkg::*;

    localparam ext_t X_MIN     = BALL_R;
    localparam ext_t X_MAX     = FIELD_W - BALL_R;
    localparam ext_t Y_MAX     = FIELD_H - BALL_R;
    localparam ext_t PAD1_FACE = BAR1_X + BAR_HW;
    localparam ext_t PAD2_FACE = BAR2_X - BAR_HW;
    localparam ext_t HIT_RANGE = BAR_HH + BALL_R;
    localparam pos_t PAD1_STOP = pos_t'(PAD1_FACE + BALL_R);
    localparam pos_t PAD2_STOP = pos_t'(PAD2_FACE - BALL_R);

    state_e state_q, state_d;
    pos_t   x_q, x_d;
    logic   dir_x_q, dir_x_d;
    cnt_t   cnt_q, cnt_d;
    logic   point1_q, point1_d;
    logic   point2_q, point2_d;

    pos_t   y_pos;
    ext_t   x_ext, y_ext, nx;
    logic   hit1, hit2, goal;

    // Vertical motion lives in the shared bounce register.
    ball_engine_bounce_axis #(
        .Min     (BALL_R),
        .Max     (Y_MAX),
        .Step    (SPEED_Y),
        .Init    (CENTRE_Y),
        .InitDir (1'b1)
    ) u_y_axis (
        .clk_i   (mclk),
        .reset_i (reset),
        .step_i  (bus_io.tick && (state_q == StMove)),
        .load_i  (state_q == StGoal),
        .pos_o   (y_pos)
    );

    // Paddle crossing, hit and goal decisions for the current step.
    always_comb begin
        x_ext = {1'b0, x_q};
        y_ext = {1'b0, y_pos};
        nx    = dir_x_q ? (x_ext + SPEED_X) : (x_ext - SPEED_X);
        hit2  = dir_x_q && (x_ext + BALL_R < PAD2_FACE) && (nx + BALL_R >= PAD2_FACE) &&
                (abs_diff(y_ext, {1'b0, bus_io.bar_2_y}) <= HIT_RANGE);
        // Left-side test with BALL_R moved across so a small nx cannot wrap.
        hit1  = !dir_x_q && (x_ext > PAD1_FACE + BALL_R) && (nx <= PAD1_FACE + BALL_R) &&
                (abs_diff(y_ext, {1'b0, bus_io.bar_1_y}) <= HIT_RANGE);
        goal  = dir_x_q ? (nx >= X_MAX) : (nx <= X_MIN);
    end

    // FSM next state: serve countdown, horizontal motion, goal scoring.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        dir_x_d  = dir_x_q;
        cnt_d    = cnt_q;
        point1_d = 1'b0;
        point2_d = 1'b0;
        unique case (state_q)
            StServe: begin
                if (bus_io.tick) begin
                    if (!bus_io.serve_en) begin
                        cnt_d = '0;
                    end else if (cnt_q == SERVE_LAST) begin
                        cnt_d   = '0;
                        state_d = StMove;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            StMove: begin
                if (bus_io.tick) begin
                    if (hit2) begin
                        x_d     = PAD2_STOP;
                        dir_x_d = 1'b0;
                    end else if (hit1) begin
                        x_d     = PAD1_STOP;
                        dir_x_d = 1'b1;
                    end else if (goal) begin
                        state_d = StGoal;
                    end else begin
                        x_d = pos_t'(nx);
                    end
                end
            end
            StGoal: begin
                // dir_x still points at the goal just entered, i.e. at the conceding player.
                point1_d = dir_x_q;
                point2_d = !dir_x_q;
                x_d      = CENTRE_X;
                cnt_d    = '0;
                state_d  = StServe;
            end
            default: state_d = StServe;
        endcase
    end

    // Registered FSM state and outputs; reset overrides any tick.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q  <= StServe;
            x_q      <= CENTRE_X;
            dir_x_q  <= 1'b1;
            cnt_q    <= '0;
            point1_q <= 1'b0;
            point2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            dir_x_q  <= dir_x_d;
            cnt_q    <= cnt_d;
            point1_q <= point1_d;
            point2_q <= point2_d;
        end
    end

    assign bus_io.x_ball = x_q;
    assign bus_io.y_ball = y_pos;
    assign bus_io.point1 = point1_q;
    assign bus_io.point2 = point2_q;

endmodule
